bitrev_checker: RTL
===================

# bitrev_checker

Synthesizable, self-checking consumer that closes the loop of the bit-reversal regression flow. It sits at the output end of the DUT. Each cycle it:
- captures the stimulus word and the DUT output,
- rebuilds the expected value by reversing the stimulus bit order,
- aligns expected and observed across the DUT latency,
- counts samples and mismatches, and records the first failure.

It reports pass/fail once a programmed number of samples has been checked, so pass/fail no longer depends on ad-hoc display statements.

## Interface
Parameters:
- W, 8, data width of stimulus and DUT output.
- LAT, 1, DUT latency in clocks (0..15); depth of the expected-value delay line.
- N_SAMPLES, 20000, number of valid comparisons before completion.
- CNT_W, 32, width of sample/error counters.
- STOP_ON_ERR, 0, 1 = finish immediately on first mismatch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a run from IDLE, DONE or FAIL.
- stim_valid  in  1  stimulus word valid this cycle.
- stim  in  W  stimulus word driven into the DUT.
- dut_out  in  W  DUT output; sampled LAT cycles after the matching stim.
- busy  out  1  run in progress.
- done  out  1  run finished (sticky until next start/reset).
- pass  out  1  valid when done; 1 = zero mismatches.
- sample_cnt  out  CNT_W  comparisons performed in current run.
- err_cnt  out  CNT_W  mismatches in current run, saturating at all-ones.
- first_err_idx  out  CNT_W  sample index of first mismatch.
- first_err_exp  out  W  expected word at first mismatch.
- first_err_got  out  W  observed word at first mismatch.

## Operation
- **Expected value:** exp[i] = stim[W-1-i] for i in 0..W-1.
- **Delay line:** exp and stim_valid pass through a LAT-deep register delay line. LAT=0 compares combinationally in the same cycle.
- **Comparison:** performed when the delayed valid is 1 and state is RUN. A mismatch is any bit difference.
  - In simulation the compare uses 4-state case inequality, so X/Z on either side is a mismatch unless both sides carry the identical value.
- **State machine:** IDLE, RUN, DONE, FAIL.
  - IDLE --start--> RUN. On entry: clear all counters and first_err_* fields, and flush the delay line.
  - RUN --(sample_cnt reaches N_SAMPLES)--> DONE.
  - RUN --(mismatch and STOP_ON_ERR=1)--> FAIL.
  - DONE / FAIL --start--> RUN, with the same clearing as from IDLE.
  - start while in RUN is ignored.
- **First error capture:** first_err_* are loaded only on the first mismatch of a run (err_cnt==0 at that compare). They are never overwritten until the next start.
- **Reset values:** state=IDLE, busy=0, done=0, pass=0, all counters and first_err_* = 0, delay line cleared.
- Reset mid-run aborts the run immediately; no partial result is retained.

## Timing
- start sampled at edge T: busy=1 from T+1.
  - Stimulus presented at T+1 or later is eligible for checking.
  - Compares begin no earlier than T+1+LAT.
- Counter update: sample_cnt increments, and err_cnt increments on a mismatch, on the same edge as the compare that uses the delayed valid.
- Completion: the edge on which the N_SAMPLES-th compare occurs sets done=1, busy=0 and pass=(err_cnt_next==0), all on that same edge.
- FAIL: done=1, busy=0 and pass=0 on the edge that registers the mismatch. Here sample_cnt includes the failing sample.
- stim_valid gaps are allowed; sample_cnt counts only valid compares.
- Saturation: err_cnt holds at 2^CNT_W-1. sample_cnt cannot overflow provided N_SAMPLES < 2^CNT_W; this is checked at elaboration.
- Outputs are registered except at LAT=0, where the compare path itself is combinational.

## Structure
- **Shared package bitrev_pkg:**
  - enum type for the four states,
  - function bitrev(W-bit) used by the checker and the reference model,
  - default constants for W and N_SAMPLES.
- **Sub-module bitrev_delay:** parameterized LAT-deep shift register carrying {valid, exp}, with synchronous flush and async reset. It is reused for any future latency-aligned comparison.
- The checker top holds the FSM, counters and first-error capture.

## Test plan
- **Clean run:** W=8, LAT=1, N_SAMPLES=16; correct reversing DUT, stim 8'h01..8'h10 each cycle -> done=1 on the 16th compare edge, pass=1, err_cnt=0, sample_cnt=16.
- **Single fault:** the DUT corrupts sample 5 (stim 8'h06 returns 8'h61 instead of 8'h60) -> err_cnt=1, first_err_idx=5, first_err_exp=8'h60, first_err_got=8'h61, pass=0.
- **Stop on error:** STOP_ON_ERR=1, fault at sample 3 -> FAIL with busy=0 and done=1 on that edge, sample_cnt=4; a later start -> RUN with counters cleared.
- **Valid gaps and latency:** LAT=3, stim_valid toggling 1,0,0,1,... -> only valid words are counted, no false mismatch, completion after exactly N_SAMPLES valid compares.
- **X propagation:** stim bit 2 = X with the DUT reversing correctly -> no mismatch. dut_out bit 5 forced to 0 while expected is X -> mismatch counted.
- **Reset mid-run:** assert rst after 7 compares -> next cycle all outputs = 0 and state = IDLE; start then behaves as a fresh run.

Source files
------------

// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reversal checker and its reference models.
package bitrev_pkg;

  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_N_SAMPLES = 20000;
  localparam int unsigned MAX_W         = 64;
  localparam int unsigned IDX_W         = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Reverse the low w bits of x (bit i takes bit w-1-i); bits at and above w stay zero.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x,
                                               input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[IDX_W'(i)] = x[IDX_W'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_delay.sv
// LAT-deep shift register carrying {valid, data} for latency-aligned compares.
module bitrev_delay #(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam int unsigned DW = W + 1;

  if (LAT == 0) begin : g_bypass
    // Zero latency: the compare sees the current word directly.
    logic unused_c;
    assign unused_c  = ^{clk, rst, flush};
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    localparam int unsigned PW = LAT * DW;
    logic [PW-1:0] pipe;

    // Newest entry enters at the bottom, oldest leaves from the top.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        pipe <= '0;
      else if (flush) pipe <= '0;
      else            pipe <= PW'({pipe, in_valid, in_data});
    end

    assign {out_valid, out_data} = pipe[PW-1 -: DW];
  end

endmodule

// File: rtl/bitrev_checker.sv
// Self-checking consumer: compares DUT output against the bit-reversed stimulus.
module bitrev_checker
  import bitrev_pkg::*;
#(
  parameter int unsigned W           = DEF_W,
  parameter int unsigned LAT         = 1,
  parameter int unsigned N_SAMPLES   = DEF_N_SAMPLES,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stim_valid,
  input  logic [W-1:0]     stim,
  input  logic [W-1:0]     dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [W-1:0]     first_err_exp,
  output logic [W-1:0]     first_err_got
);

  // Reject parameter sets the counters or delay line cannot honour.
  if (W == 0 || W > MAX_W) begin : g_bad_w
    $error("bitrev_checker: W must be 1..%0d", MAX_W);
  end
  if (LAT > 15) begin : g_bad_lat
    $error("bitrev_checker: LAT must be 0..15");
  end
  if (N_SAMPLES == 0 ||
      (CNT_W < 32 && 64'(N_SAMPLES) >= (64'd1 << CNT_W))) begin : g_bad_n
    $error("bitrev_checker: N_SAMPLES must be nonzero and below 2**CNT_W");
  end

  state_t           state, state_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [CNT_W-1:0] scnt_nxt, ecnt_nxt, fidx_nxt;
  logic [W-1:0]     fexp_nxt, fgot_nxt;
  logic             flush_c;
  logic [W-1:0]     exp_c;
  logic             d_valid;
  logic [W-1:0]     d_exp;
  logic             compare_c, mismatch_c;

  assign exp_c = W'(bitrev(MAX_W'(stim), W));

  bitrev_delay #(.W(W), .LAT(LAT)) u_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_c),
    .in_valid  (stim_valid),
    .in_data   (exp_c),
    .out_valid (d_valid),
    .out_data  (d_exp)
  );

  // Case inequality: X/Z only matches an identical X/Z on the other side.
  assign compare_c  = (state == ST_RUN) && d_valid;
  assign mismatch_c = compare_c && (d_exp !== dut_out);

  // Next-state, counter and first-error logic.
  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    scnt_nxt  = sample_cnt;
    ecnt_nxt  = err_cnt;
    fidx_nxt  = first_err_idx;
    fexp_nxt  = first_err_exp;
    fgot_nxt  = first_err_got;
    flush_c   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_nxt = ST_RUN;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          scnt_nxt  = '0;
          ecnt_nxt  = '0;
          fidx_nxt  = '0;
          fexp_nxt  = '0;
          fgot_nxt  = '0;
          flush_c   = 1'b1;
        end
      end
      ST_RUN: begin
        if (compare_c) begin
          scnt_nxt = sample_cnt + CNT_W'(1);
          if (mismatch_c) begin
            if (err_cnt != '1) ecnt_nxt = err_cnt + CNT_W'(1);
            if (err_cnt == '0) begin
              fidx_nxt = sample_cnt;
              fexp_nxt = d_exp;
              fgot_nxt = dut_out;
            end
          end
          if (mismatch_c && (STOP_ON_ERR != 0)) begin
            state_nxt = ST_FAIL;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = 1'b0;
          end else if (scnt_nxt == CNT_W'(N_SAMPLES)) begin
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (ecnt_nxt == '0);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered results; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      sample_cnt    <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      state         <= state_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      pass          <= pass_nxt;
      sample_cnt    <= scnt_nxt;
      err_cnt       <= ecnt_nxt;
      first_err_idx <= fidx_nxt;
      first_err_exp <= fexp_nxt;
      first_err_got <= fgot_nxt;
    end
  end

endmodule
